// File: rtl/data_structures_pkg.sv
// Shared core-wide sizing constants used by the register file and its neighbours.
package data_structures;

  localparam int GPR_SIZE     = 64;
  localparam int GPR_IDX_SIZE = 5;
  localparam int ROB_IDX_SIZE = 5;

endpackage : data_structures

// File: rtl/regfile_module.sv
// Architectural register file: one commit write port from the ROB and two registered
// dispatch read ports, with same-edge write-to-read bypass and a hardwired zero at the top index.
module regfile_module #(
  parameter int GPR_SIZE     = data_structures::GPR_SIZE,
  parameter int GPR_IDX_SIZE = data_structures::GPR_IDX_SIZE
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rob_should_commit,
  input  logic [GPR_SIZE-1:0]     in_rob_commit_value,
  input  logic [GPR_IDX_SIZE-1:0] in_rob_regfile_index,
  input  logic                    in_dispatch_should_read,
  input  logic [GPR_IDX_SIZE-1:0] in_d_op1,
  input  logic [GPR_IDX_SIZE-1:0] in_d_op2,
  output logic [GPR_SIZE-1:0]     out_d_op1,
  output logic [GPR_SIZE-1:0]     out_d_op2
);

  localparam int                    NUM_REGS = 1 << GPR_IDX_SIZE;
  localparam logic [GPR_IDX_SIZE-1:0] ZERO_IDX = '1;

  logic [GPR_SIZE-1:0] regs_q [NUM_REGS];
  logic [GPR_SIZE-1:0] regs_d [NUM_REGS];
  logic [GPR_SIZE-1:0] op1_q, op1_d;
  logic [GPR_SIZE-1:0] op2_q, op2_d;
  logic                commit_en;

  // The zero register is never written, so its storage stays at its reset value of 0.
  assign commit_en = in_rob_should_commit && (in_rob_regfile_index != ZERO_IDX);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (commit_en) begin
      regs_d[in_rob_regfile_index] = in_rob_commit_value;
    end
  end

  always_comb begin
    op1_d = op1_q;
    if (in_dispatch_should_read) begin
      if (in_d_op1 == ZERO_IDX) begin
        op1_d = '0;
      end else if (commit_en && (in_d_op1 == in_rob_regfile_index)) begin
        op1_d = in_rob_commit_value;
      end else begin
        op1_d = regs_q[in_d_op1];
      end
    end
  end

  always_comb begin
    op2_d = op2_q;
    if (in_dispatch_should_read) begin
      if (in_d_op2 == ZERO_IDX) begin
        op2_d = '0;
      end else if (commit_en && (in_d_op2 == in_rob_regfile_index)) begin
        op2_d = in_rob_commit_value;
      end else begin
        op2_d = regs_q[in_d_op2];
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      op1_q <= op1_d;
      op2_q <= op2_d;
    end
  end

  assign out_d_op1 = op1_q;
  assign out_d_op2 = op2_q;

endmodule : regfile_module

// File: tb/tb_regfile_module.sv
// Randomised self-checking bench for regfile_module against an array-based register model.
module tb_regfile_module;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_rob_should_commit;
  logic [63:0] in_rob_commit_value;
  logic [4:0]  in_rob_regfile_index;
  logic        in_dispatch_should_read;
  logic [4:0]  in_d_op1;
  logic [4:0]  in_d_op2;
  logic [63:0] out_d_op1;
  logic [63:0] out_d_op2;

  regfile_module dut (
    .in_clk                 (in_clk),
    .in_rst                 (in_rst),
    .in_rob_should_commit   (in_rob_should_commit),
    .in_rob_commit_value    (in_rob_commit_value),
    .in_rob_regfile_index   (in_rob_regfile_index),
    .in_dispatch_should_read(in_dispatch_should_read),
    .in_d_op1               (in_d_op1),
    .in_d_op2               (in_d_op2),
    .out_d_op1              (out_d_op1),
    .out_d_op2              (out_d_op2)
  );

  always #5 in_clk = ~in_clk;

  // Reference state: architectural register values and the last values a read delivered.
  logic [63:0] model_regs [32];
  logic [63:0] model_op1;
  logic [63:0] model_op2;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Architectural view of one edge: reset wipes everything; otherwise the commit lands
  // first (x31 reads as zero regardless), and reads observe the post-commit state.
  task automatic model_edge(input logic rst, input logic cm, input logic [4:0] ci,
                            input logic [63:0] cv, input logic rd,
                            input logic [4:0] a, input logic [4:0] b);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
      model_op1 = 64'd0;
      model_op2 = 64'd0;
    end else begin
      if (cm) model_regs[ci] = cv;
      model_regs[31] = 64'd0;
      if (rd) begin
        model_op1 = model_regs[a];
        model_op2 = model_regs[b];
      end
    end
  endtask

  task automatic step(input string name, input logic rst, input logic cm, input logic [4:0] ci,
                      input logic [63:0] cv, input logic rd,
                      input logic [4:0] a, input logic [4:0] b);
    in_rst                  = rst;
    in_rob_should_commit    = cm;
    in_rob_regfile_index    = ci;
    in_rob_commit_value     = cv;
    in_dispatch_should_read = rd;
    in_d_op1                = a;
    in_d_op2                = b;
    @(posedge in_clk);
    #1;
    model_edge(rst, cm, ci, cv, rd, a, b);
    check($sformatf("%s.op1", name), out_d_op1, model_op1);
    check($sformatf("%s.op2", name), out_d_op2, model_op2);
  endtask

  initial begin
    logic        r_rst, r_cm, r_rd;
    logic [4:0]  r_ci, r_a, r_b;
    logic [63:0] r_cv;

    for (int i = 0; i < 32; i++) model_regs[i] = 64'hX;
    model_op1 = 64'hX;
    model_op2 = 64'hX;
    in_rst = 1'b1;
    in_rob_should_commit = 1'b0;
    in_rob_commit_value = '0;
    in_rob_regfile_index = '0;
    in_dispatch_should_read = 1'b0;
    in_d_op1 = '0;
    in_d_op2 = '0;
    @(negedge in_clk);

    // Reset, then read x0/x5.
    step("reset",      1, 0, 5'd0,  64'd0, 0, 5'd0, 5'd0);
    step("rst_read",   0, 0, 5'd0,  64'd0, 1, 5'd0, 5'd5);
    // Commit then read on the next edge.
    step("commit_x1",  0, 1, 5'd1,  64'h0000_0000_0000_0FFF, 0, 5'd0, 5'd0);
    step("read_x1",    0, 0, 5'd0,  64'd0, 1, 5'd1, 5'd1);
    check("x1_literal", out_d_op1, 64'h0FFF);
    // Hold while read disabled, then re-enable.
    step("hold",       0, 1, 5'd1,  64'h5, 0, 5'd9, 5'd4);
    check("hold_literal", out_d_op1, 64'h0FFF);
    step("reread_x1",  0, 0, 5'd0,  64'd0, 1, 5'd1, 5'd2);
    check("reread_literal", out_d_op1, 64'h5);
    // Same-edge bypass on port 1 only.
    step("bypass_x7",  0, 1, 5'd7,  64'hDEAD_BEEF_0000_0001, 1, 5'd7, 5'd3);
    check("bypass_literal", out_d_op1, 64'hDEAD_BEEF_0000_0001);
    // Both ports bypass simultaneously.
    step("bypass_both",0, 1, 5'd12, 64'hA5A5_0000_1111_2222, 1, 5'd12, 5'd12);
    // Zero register: commit discarded and reads return 0, also under bypass.
    step("commit_x31", 0, 1, 5'd31, 64'h1234, 1, 5'd31, 5'd7);
    step("read_x31",   0, 0, 5'd0,  64'd0, 1, 5'd31, 5'd1);
    check("x31_literal", out_d_op1, 64'd0);
    // Reset on the same edge as a commit and read.
    step("rst_mid",    1, 1, 5'd2,  64'h9, 1, 5'd2, 5'd2);
    step("after_rst",  0, 0, 5'd0,  64'd0, 1, 5'd2, 5'd1);

    // Randomised traffic with biased index collisions and occasional resets.
    for (int n = 0; n < 600; n++) begin
      r_rst = ($urandom_range(0, 79) == 0);
      r_cm  = $urandom_range(0, 1);
      r_rd  = ($urandom_range(0, 9) < 7);
      r_ci  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      r_cv  = {$urandom, $urandom};
      r_a   = ($urandom_range(0, 3) == 0) ? r_ci : 5'($urandom_range(0, 31));
      r_b   = ($urandom_range(0, 3) == 0) ? r_ci : 5'($urandom_range(0, 31));
      step($sformatf("rand%0d", n), r_rst, r_cm, r_ci, r_cv, r_rd, r_a, r_b);
    end

    // Final sweep of every register without commits.
    for (int i = 0; i < 32; i += 2) begin
      step($sformatf("sweep%0d", i), 0, 0, 5'd0, 64'd0, 1, 5'(i), 5'(i + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_regfile_module

// File: doc/regfile_module.md
REGFILE_MODULE -- requirements
Module: regfile_module

Interface
REQ-001 Parameters SHALL be:
- GPR_SIZE, default 64, register data width.
- GPR_IDX_SIZE, default 5, register index width.
- Both values come from the shared package.

REQ-002 Ports SHALL be:
- in_clk  input  1  single clock; all state updates on its rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_rob_should_commit  input  1  ROB commit-write enable.
- in_rob_commit_value  input  GPR_SIZE  value to commit.
- in_rob_regfile_index  input  GPR_IDX_SIZE  destination register of the commit.
- in_dispatch_should_read  input  1  dispatch read enable.
- in_d_op1  input  GPR_IDX_SIZE  source register index, port 1.
- in_d_op2  input  GPR_IDX_SIZE  source register index, port 2.
- out_d_op1  output  GPR_SIZE  registered read data, port 1.
- out_d_op2  output  GPR_SIZE  registered read data, port 2.

Function
REQ-003 Storage SHALL be 2^GPR_IDX_SIZE entries of GPR_SIZE bits each (32 x 64 bits by default).

REQ-004 Index 31 (all-ones index) SHALL be the zero register:
- Reads of index 31 return 0.
- Commits to index 31 are discarded.

REQ-005 Commit: on a rising edge where in_rob_should_commit=1 and in_rst=0:
- entry[in_rob_regfile_index] <= in_rob_commit_value (subject to REQ-004).
- No other entry changes.

REQ-006 When in_rob_should_commit=0, register contents SHALL be unchanged.

REQ-007 Read: on a rising edge where in_dispatch_should_read=1 and in_rst=0:
- out_d_op1 <= value of register in_d_op1.
- out_d_op2 <= value of register in_d_op2.
- Read latency is exactly 1 cycle.

REQ-008 When in_dispatch_should_read=0, out_d_op1 and out_d_op2 SHALL hold their previous values.

REQ-009 Write-to-read bypass: if a commit and a read occur on the same edge and a read index equals in_rob_regfile_index (and is not 31), that output SHALL capture in_rob_commit_value, not the old contents.

REQ-010 Both read ports SHALL be independent:
- The same index on both ports returns the same value on both outputs.
- Both ports may bypass simultaneously.

REQ-011 All input values SHALL be fully defined; no index is out of range, since indices span exactly the register array.

REQ-012 The block SHALL have no handshake or back-pressure. A commit and a read are each accepted on every enabled edge.

Reset
REQ-013 On a rising edge with in_rst=1:
- All registers clear to 0.
- out_d_op1 and out_d_op2 clear to 0.
- Any commit or read on that edge is ignored.

REQ-014 The first edge with in_rst=0 after reset SHALL behave normally. If reset is asserted mid-operation, in-flight commit/read requests on the reset edge are lost, not deferred.

Structure
REQ-015 The shared package (data_structures) SHALL hold GPR_SIZE, GPR_IDX_SIZE and ROB_IDX_SIZE. The module SHALL import these constants, not redefine them.

REQ-016 The block SHALL be a single module with no sub-modules:
- one storage array;
- two read paths, each with its own bypass mux;
- one write path.

Verification
REQ-017 Reset:
- Stimulus: assert in_rst for 1 edge, then read indices 0 and 5.
- Response: out_d_op1=0 and out_d_op2=0 one cycle later.

REQ-018 Commit then read:
- Stimulus: commit 0x0000_0000_0000_0FFF to x1, then read in_d_op1=1 and in_d_op2=1 on the next edge.
- Response: both outputs equal 0xFFF after that edge.

REQ-019 Same-edge bypass:
- Stimulus: commit 0xDEAD_BEEF_0000_0001 to x7 while reading in_d_op1=7 and in_d_op2=3 (x3=0).
- Response: out_d_op1=0xDEAD_BEEF_0000_0001 and out_d_op2=0.

REQ-020 Zero register:
- Stimulus: commit 0x1234 to index 31, then read index 31.
- Response: output 0; all other registers unchanged.

REQ-021 Hold:
- Stimulus: after reading x1=0xFFF, deassert in_dispatch_should_read, commit 0x5 to x1, and change in_d_op1.
- Response: out_d_op1 stays 0xFFF; re-enabling the read yields 0x5.

REQ-022 Reset mid-operation:
- Stimulus: assert in_rst on the same edge as a commit of 0x9 to x2 and a read of x2.
- Response: outputs 0; a subsequent read of x2 returns 0.
